// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner with an iterative shift-add multiplier and restoring divider (WIDTH iterations each).
// Optional pipeline-flush input enabled by defining HILO_MULDIV_ABORT_EN.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
`ifdef HILO_MULDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic [WIDTH-1:0]     rem_reg, rem_next;
  logic [WIDTH-1:0]     quo_reg, quo_next;
  logic [WIDTH-1:0]     dvsr_reg, dvsr_next;
  logic [WIDTH-1:0]     rs_raw_reg, rs_raw_next;
  logic                 is_div_reg, is_div_next;
  logic                 neg_q_reg, neg_q_next;
  logic                 neg_r_reg, neg_r_next;
  logic                 dz_reg, dz_next;
  logic [WIDTH-1:0]     hi_reg, hi_next;
  logic [WIDTH-1:0]     lo_reg, lo_next;
  logic                 done_reg, done_next;
  logic                 dbz_reg, dbz_next;

  logic                 abort_int;
  logic                 rs_neg, rt_neg;
  logic [WIDTH-1:0]     rs_mag, rt_mag;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   prod;

`ifdef HILO_MULDIV_ABORT_EN
  assign abort_int = abort;
`else
  assign abort_int = 1'b0;
`endif

  // Signed ops (even op codes) work on magnitudes; signs are reapplied in FIX.
  assign rs_neg = ~op[0] & rs_val[WIDTH-1];
  assign rt_neg = ~op[0] & rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvsr_reg   <= '0;
      rs_raw_reg <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      dvsr_reg   <= dvsr_next;
      rs_raw_reg <= rs_raw_next;
      is_div_reg <= is_div_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      dz_reg     <= dz_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_reg   <= done_next;
      dbz_reg    <= dbz_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    dvsr_next   = dvsr_reg;
    rs_raw_next = rs_raw_reg;
    is_div_next = is_div_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    dz_next     = dz_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;
    dbz_next    = 1'b0;
    trial       = {rem_reg, quo_reg[WIDTH-1]};
    prod        = neg_q_reg ? -acc_reg : acc_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_next  = S_RUN;
              cnt_next    = '0;
              acc_next    = '0;
              mcand_next  = {{WIDTH{1'b0}}, rs_mag};
              mplier_next = rt_mag;
              rem_next    = '0;
              quo_next    = rs_mag;
              dvsr_next   = rt_mag;
              rs_raw_next = rs_val;
              is_div_next = op[1];
              neg_q_next  = rs_neg ^ rt_neg;
              neg_r_next  = rs_neg;
              dz_next     = (rt_val == '0);
            end
            OP_MTHI: hi_next = rs_val;
            OP_MTLO: lo_next = rs_val;
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (abort_int) begin
          state_next = S_IDLE;
        end else begin
          if (is_div_reg) begin
            // Restoring step: shift in the next dividend bit, subtract if it fits.
            if (trial >= {1'b0, dvsr_reg}) begin
              rem_next = WIDTH'(trial - {1'b0, dvsr_reg});
              quo_next = {quo_reg[WIDTH-2:0], 1'b1};
            end else begin
              rem_next = trial[WIDTH-1:0];
              quo_next = {quo_reg[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (mplier_reg[0]) acc_next = acc_reg + mcand_reg;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
          end
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1)) state_next = S_FIX;
        end
      end

      S_FIX: begin
        if (abort_int) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_DONE;
          done_next  = 1'b1;
          if (is_div_reg) begin
            if (dz_reg) begin
              hi_next  = rs_raw_reg;
              lo_next  = '1;
              dbz_next = 1'b1;
            end else begin
              lo_next = neg_q_reg ? -quo_reg : quo_reg;
              hi_next = neg_r_reg ? -rem_reg : rem_reg;
            end
          end else begin
            {hi_next, lo_next} = prod;
          end
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg == S_RUN) || (state_reg == S_FIX);
  assign done = done_reg;
  assign dbz  = dbz_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
